// File: rtl/sequential_accumulate_stage_pkg.sv
// Shared definitions for the sequential accumulate stage.
//   acc_state_t : FSM state encoding (ACCUM = 1'b0, HOLD = 1'b1)
//   clog2_safe  : ceil(log2(n)), returning 0 for n <= 1
package sequential_accumulate_stage_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Counter width; never zero so a COUNT=1 build still has a real register.
  function automatic int cnt_width(input int n);
    return (clog2_safe(n) == 0) ? 1 : clog2_safe(n);
  endfunction

endpackage

// File: rtl/sample_group_counter.sv
// Mod-COUNT sample counter for the accumulate stage.
//   CLK, ASYNCRESETN : clock and asynchronous active-low reset
//   inc              : count one accepted sample (wraps COUNT-1 -> 0)
//   load1            : restart at 1 (first sample of a group taken in HOLD)
//   cnt              : current position inside the group
//   last             : cnt == COUNT-1
module sample_group_counter
  import sequential_accumulate_stage_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int CW    = cnt_width(COUNT)
) (
  input  logic          CLK,
  input  logic          ASYNCRESETN,
  input  logic          inc,
  input  logic          load1,
  output logic [CW-1:0] cnt,
  output logic          last
);

  localparam logic [CW-1:0] LAST_VAL = CW'(COUNT - 1);
  // With COUNT=1 every sample closes a group, so "one" is really zero.
  localparam logic [CW-1:0] ONE_VAL  = (COUNT > 1) ? CW'(1) : '0;

  assign last = (cnt == LAST_VAL);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= ONE_VAL;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sequential_accumulate_stage.sv
// Sums every COUNT accepted input samples and emits one widened, registered sum.
//   CLK, ASYNCRESETN : clock and asynchronous active-low reset
//   CE               : clock enable; low freezes all state and drops both handshakes
//   I0 / valid_data_in / ready_data_in    : input sample stream
//   O0 / valid_data_out / ready_data_out  : group sum stream
//   dbg_state        : current FSM state (ACCUM/HOLD) for observation
//
// Handshake rule (both sides): a transfer happens on a rising CLK edge where
// valid and ready are both 1 (and CE=1). A producer holding valid=1 keeps its
// data stable until that transfer; O0 never changes while valid_data_out=1 and
// ready_data_out=0.
module sequential_accumulate_stage
  import sequential_accumulate_stage_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 4,
  parameter int OUT_WIDTH = WIDTH + $clog2(COUNT)
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 CE,
  input  logic [WIDTH-1:0]     I0,
  input  logic                 valid_data_in,
  output logic                 ready_data_in,
  output logic [OUT_WIDTH-1:0] O0,
  output logic                 valid_data_out,
  input  logic                 ready_data_out,
  output logic                 dbg_state
);

  localparam int CW = cnt_width(COUNT);

  acc_state_t           state, state_nxt;
  logic [OUT_WIDTH-1:0] acc, acc_nxt, o_nxt;
  logic [OUT_WIDTH-1:0] sample_ext;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 cnt_inc, cnt_load1;
  logic                 in_fire, out_fire;

  // ready_data_out feeds ready_data_in combinationally so a HOLD cycle can
  // hand off the sum and take the next group's first sample together.
  assign ready_data_in  = CE & ((state == ACCUM) | ready_data_out);
  assign valid_data_out = CE & (state == HOLD);
  assign in_fire        = valid_data_in & ready_data_in;
  assign out_fire       = valid_data_out & ready_data_out;
  assign sample_ext     = OUT_WIDTH'(I0);
  assign dbg_state      = state;

  sample_group_counter #(.COUNT(COUNT), .CW(CW)) u_counter (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .inc         (cnt_inc),
    .load1       (cnt_load1),
    .cnt         (cnt),
    .last        (last)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    o_nxt     = O0;
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    case (state)
      ACCUM: begin
        if (in_fire) begin
          cnt_inc = 1'b1;
          if (last) begin
            o_nxt     = acc + sample_ext;
            acc_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            acc_nxt = acc + sample_ext;
          end
        end
      end
      HOLD: begin
        // In HOLD, in_fire implies out_fire (ready_data_in tracks ready_data_out).
        if (out_fire) begin
          if (in_fire) begin
            if (COUNT > 1) begin
              acc_nxt   = sample_ext;
              cnt_load1 = 1'b1;
              state_nxt = ACCUM;
            end else begin
              o_nxt = sample_ext;
            end
          end else begin
            state_nxt = ACCUM;
          end
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= ACCUM;
      acc   <= '0;
      O0    <= '0;
    end else if (CE) begin
      state <= state_nxt;
      acc   <= acc_nxt;
      O0    <= o_nxt;
    end
  end

endmodule
